// File: rtl/filter_pkg.sv
// Shared definitions for the filter frame sequencer: sequencer state
// encoding, default image geometry and width-derivation helpers.
package filter_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 8;
    localparam int unsigned DEF_WIDTH_IMAG  = 4;
    localparam int unsigned DEF_HEIGHT_IMAG = 4;
    localparam int unsigned DEF_HBLANK      = 2;
    localparam int unsigned DEF_VBLANK      = 2;
    localparam int unsigned DEF_TIMEOUT     = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        VLEAD = 3'd1,
        ROW   = 3'd2,
        HGAP  = 3'd3,
        FLUSH = 3'd4
    } seq_state_t;

    // Pixels per frame
    function automatic int unsigned calc_npix(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    // Linear pixel address width (at least one bit)
    function automatic int unsigned calc_addr_w(input int unsigned w, input int unsigned h);
        return (w * h > 1) ? $clog2(w * h) : 1;
    endfunction

    // Width of a counter that must hold values 0..max_val
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/frame_result_writer.sv
// Collects filter results into the destination RAM.
// Ports: clk/rst, clear (new frame), busy (frame active), i_wr_file/i_data_out
// (filter results), wr_en/wr_addr/wr_data (destination RAM, combinational),
// done (registered pulse after the last write), last_write_c/frame_full_c
// (completion status for the sequencer), overflow_c (only with
// FRAME_SEQ_ERR_CHK_EN: result arrived with the frame already full).
module frame_result_writer
    import filter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NPIX       = DEF_WIDTH_IMAG * DEF_HEIGHT_IMAG,
    parameter int unsigned ADDR_W     = calc_addr_w(DEF_WIDTH_IMAG, DEF_HEIGHT_IMAG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  busy,
    input  logic                  i_wr_file,
    input  logic [DATA_WIDTH-1:0] i_data_out,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  done,
    output logic                  last_write_c,
`ifdef FRAME_SEQ_ERR_CHK_EN
    output logic                  overflow_c,
`endif
    output logic                  frame_full_c
);

    localparam int unsigned WCNT_W = cnt_w(NPIX);

    logic [WCNT_W-1:0] wcount;

    // Results are accepted only inside a frame and only until the frame is full
    assign frame_full_c = (wcount == WCNT_W'(NPIX));
    assign wr_en        = busy && i_wr_file && !frame_full_c;
    assign last_write_c = wr_en && (wcount == WCNT_W'(NPIX - 1));
    assign wr_addr      = ADDR_W'(wcount);
    assign wr_data      = i_data_out;
`ifdef FRAME_SEQ_ERR_CHK_EN
    assign overflow_c   = busy && i_wr_file && frame_full_c;
`endif

    // Write counter and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcount <= '0;
            done   <= 1'b0;
        end else begin
            done <= last_write_c;
            if (clear)
                wcount <= '0;
            else if (wr_en)
                wcount <= wcount + WCNT_W'(1);
        end
    end

endmodule

// File: rtl/filter_frame_sequencer.sv
// Frame sequencer in front of the 3x3 filter: reads a source frame from a
// 1-cycle-latency RAM, frames it with o_hav/o_vav for the filter, and writes
// the filter results to a destination RAM, pulsing done on completion.
// Ports: clk, rst (async, active-high), start, busy, done, rd_en/rd_addr/
// rd_data (source RAM), o_hav/o_vav/o_data (filter input), i_wr_file/
// i_data_out (filter output), wr_en/wr_addr/wr_data (destination RAM),
// err (sticky, only when FRAME_SEQ_ERR_CHK_EN is defined).
// Optional feature macro: FRAME_SEQ_ERR_CHK_EN (FLUSH watchdog + overflow flag).
module filter_frame_sequencer
    import filter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned WIDTH_IMAG  = DEF_WIDTH_IMAG,
    parameter int unsigned HEIGHT_IMAG = DEF_HEIGHT_IMAG,
    parameter int unsigned HBLANK      = DEF_HBLANK,
    parameter int unsigned VBLANK      = DEF_VBLANK
`ifdef FRAME_SEQ_ERR_CHK_EN
    ,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
`endif
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         rd_en,
    output logic [calc_addr_w(WIDTH_IMAG, HEIGHT_IMAG)-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]                        rd_data,
    output logic                                         o_hav,
    output logic                                         o_vav,
    output logic [DATA_WIDTH-1:0]                        o_data,
    input  logic                                         i_wr_file,
    input  logic [DATA_WIDTH-1:0]                        i_data_out,
    output logic                                         wr_en,
    output logic [calc_addr_w(WIDTH_IMAG, HEIGHT_IMAG)-1:0] wr_addr,
`ifdef FRAME_SEQ_ERR_CHK_EN
    output logic                                         err,
`endif
    output logic [DATA_WIDTH-1:0]                        wr_data
);

    localparam int unsigned ADDR_W = calc_addr_w(WIDTH_IMAG, HEIGHT_IMAG);
    localparam int unsigned NPIX   = calc_npix(WIDTH_IMAG, HEIGHT_IMAG);
    localparam int unsigned COL_W  = cnt_w(WIDTH_IMAG - 1);
    localparam int unsigned ROW_W  = cnt_w(HEIGHT_IMAG - 1);
    localparam int unsigned BLK_W  = cnt_w((VBLANK > HBLANK) ? VBLANK : HBLANK);
`ifdef FRAME_SEQ_ERR_CHK_EN
    localparam int unsigned TMO_W  = cnt_w(TIMEOUT);
`endif

    seq_state_t        state, state_nxt;
    logic [COL_W-1:0]  col, col_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic [BLK_W-1:0]  blk, blk_nxt;
    logic              start_acc_c;
    logic              last_write_c;
    logic              frame_full_c;
`ifdef FRAME_SEQ_ERR_CHK_EN
    logic [TMO_W-1:0]  tcnt, tcnt_nxt;
    logic              timeout_c;
    logic              overflow_c;
`endif

    assign o_data = rd_data;

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            blk   <= '0;
`ifdef FRAME_SEQ_ERR_CHK_EN
            tcnt  <= '0;
`endif
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
            blk   <= blk_nxt;
`ifdef FRAME_SEQ_ERR_CHK_EN
            tcnt  <= tcnt_nxt;
`endif
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nxt   = state;
        col_nxt     = col;
        row_nxt     = row;
        blk_nxt     = blk;
        start_acc_c = 1'b0;
`ifdef FRAME_SEQ_ERR_CHK_EN
        timeout_c   = 1'b0;
        tcnt_nxt    = (state == FLUSH) ? tcnt + TMO_W'(1) : '0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = VLEAD;
                    start_acc_c = 1'b1;
                    col_nxt     = '0;
                    row_nxt     = '0;
                    blk_nxt     = '0;
                end
            end
            VLEAD: begin
                if (blk == BLK_W'(VBLANK - 1)) begin
                    state_nxt = ROW;
                    blk_nxt   = '0;
                end else begin
                    blk_nxt = blk + BLK_W'(1);
                end
            end
            ROW: begin
                if (col == COL_W'(WIDTH_IMAG - 1)) begin
                    col_nxt = '0;
                    if (row == ROW_W'(HEIGHT_IMAG - 1)) begin
                        state_nxt = FLUSH;
                    end else begin
                        row_nxt   = row + ROW_W'(1);
                        blk_nxt   = '0;
                        state_nxt = HGAP;
                    end
                end else begin
                    col_nxt = col + COL_W'(1);
                end
            end
            HGAP: begin
                if (blk == BLK_W'(HBLANK - 1)) begin
                    state_nxt = ROW;
                    blk_nxt   = '0;
                end else begin
                    blk_nxt = blk + BLK_W'(1);
                end
            end
            FLUSH: begin
                if (last_write_c || frame_full_c) begin
                    state_nxt = IDLE;
                end
`ifdef FRAME_SEQ_ERR_CHK_EN
                else if (tcnt == TMO_W'(TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                    timeout_c = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, aligned with the state they describe.
    // o_vav stays up through FLUSH only while the last row's o_hav is still high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            rd_en   <= 1'b0;
            o_hav   <= 1'b0;
            o_vav   <= 1'b0;
            rd_addr <= '0;
        end else begin
            busy    <= (state_nxt != IDLE);
            rd_en   <= (state_nxt == ROW);
            o_hav   <= rd_en;
            o_vav   <= (state_nxt inside {VLEAD, ROW, HGAP}) ||
                       ((state_nxt == FLUSH) && rd_en);
            if (start_acc_c)
                rd_addr <= '0;
            else if (rd_en)
                rd_addr <= rd_addr + ADDR_W'(1);
        end
    end

`ifdef FRAME_SEQ_ERR_CHK_EN
    // Sticky error: FLUSH watchdog expiry or result beyond the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (timeout_c || overflow_c)
            err <= 1'b1;
    end
`endif

    frame_result_writer #(
        .DATA_WIDTH (DATA_WIDTH),
        .NPIX       (NPIX),
        .ADDR_W     (ADDR_W)
    ) u_writer (
        .clk          (clk),
        .rst          (rst),
        .clear        (start_acc_c),
        .busy         (busy),
        .i_wr_file    (i_wr_file),
        .i_data_out   (i_data_out),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .done         (done),
        .last_write_c (last_write_c),
`ifdef FRAME_SEQ_ERR_CHK_EN
        .overflow_c   (overflow_c),
`endif
        .frame_full_c (frame_full_c)
    );

endmodule
